// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT stage sequencer.
package fft_pkg;

  localparam int FFT_MAX_LOG2N = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BITREV,
    ST_BRDRAIN,
    ST_BFLY,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  // Reverse the low m bits of value; bits at or above m come back as zero.
  function automatic logic [FFT_MAX_LOG2N-1:0] bit_reverse(
    input logic [FFT_MAX_LOG2N-1:0] value,
    input logic [3:0]               m
  );
    logic [FFT_MAX_LOG2N-1:0] full_rev;
    for (int j = 0; j < FFT_MAX_LOG2N; j++) begin
      full_rev[j] = value[FFT_MAX_LOG2N-1-j];
    end
    return full_rev >> (FFT_MAX_LOG2N - m);
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with a synchronous flush, used to line the
// write-back addresses up with the butterfly pipeline output.
module fft_delay_line
  import fft_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q;
  logic [DEPTH-1:0][WIDTH-1:0] pipe_d;

  // Shift one slot per cycle, or clear every slot on flush.
  always_comb begin
    pipe_d = pipe_q;
    if (i_flush) begin
      pipe_d = '0;
    end else begin
      pipe_d[0] = i_data;
      for (int j = 1; j < DEPTH; j++) begin
        pipe_d[j] = pipe_q[j-1];
      end
    end
  end

  // Pipeline storage with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign o_data = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences the in-place radix-2 DIT FFT: a bit-reversal swap pass followed
// by log2(N) butterfly stages, with drain gaps covering the butterfly latency.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int BF_LATENCY = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_samples_number,
  output logic                  o_busy,
  output logic                  o_calc_end,
  output logic                  o_cfg_err,
  output logic [3:0]            o_stage,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr_a,
  output logic [ADDR_WIDTH-1:0] o_rd_addr_b,
  output logic [ADDR_WIDTH-2:0] o_tw_idx,
  output logic                  o_bf_bypass,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr_a,
  output logic [ADDR_WIDTH-1:0] o_wr_addr_b
);

  localparam int DL_WIDTH = 2 + 2 * ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] DRAIN_LAST = ADDR_WIDTH'(BF_LATENCY - 1);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [3:0]            m_q, m_d;
  logic [3:0]            s_q, s_d;
  logic                  cfg_err_q, cfg_err_d;

  logic                  n_legal;
  logic [3:0]            n_log2;

  logic [ADDR_WIDTH-1:0] span, pos, bf_a, rev_idx;
  logic                  rd_en, rd_bypass;
  logic [ADDR_WIDTH-1:0] rd_a, rd_b;
  logic [ADDR_WIDTH-2:0] tw;

  logic [DL_WIDTH-1:0]   dl_in, dl_out;
  logic                  wr_bypass;
  logic [ADDR_WIDTH-1:0] wr_a, wr_b;

  // Accept only powers of two from 2 up to the largest supported frame.
  always_comb begin
    n_legal = 1'b0;
    n_log2  = '0;
    for (int j = 1; j <= FFT_MAX_LOG2N; j++) begin
      if (i_samples_number == (ADDR_WIDTH'(1) << j)) begin
        n_legal = 1'b1;
        n_log2  = 4'(j);
      end
    end
  end

  // Next-state and counter logic; abort overrides everything else.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    m_d       = m_q;
    s_d       = s_q;
    idx_d     = idx_q;
    cfg_err_d = 1'b0;
    if (i_abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      s_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            if (n_legal) begin
              state_d = ST_BITREV;
              n_d     = i_samples_number;
              m_d     = n_log2;
              s_d     = '0;
              idx_d   = '0;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        ST_BITREV: begin
          if (idx_q == n_q - ADDR_WIDTH'(1)) begin
            state_d = ST_BRDRAIN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ADDR_WIDTH'(1);
          end
        end
        ST_BRDRAIN: begin
          if (idx_q == DRAIN_LAST) begin
            state_d = ST_BFLY;
            idx_d   = '0;
            s_d     = '0;
          end else begin
            idx_d = idx_q + ADDR_WIDTH'(1);
          end
        end
        ST_BFLY: begin
          if (idx_q == (n_q >> 1) - ADDR_WIDTH'(1)) begin
            state_d = ST_DRAIN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ADDR_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (idx_q == DRAIN_LAST) begin
            idx_d = '0;
            if (s_q == m_q - 4'd1) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_BFLY;
              s_d     = s_q + 4'd1;
            end
          end else begin
            idx_d = idx_q + ADDR_WIDTH'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      m_q       <= '0;
      s_q       <= '0;
      idx_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      m_q       <= m_d;
      s_q       <= s_d;
      idx_q     <= idx_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Read-pair address generation for the swap pass and the butterfly stages.
  always_comb begin
    span      = ADDR_WIDTH'(1) << s_q;
    pos       = idx_q & (span - ADDR_WIDTH'(1));
    bf_a      = ((idx_q >> s_q) << (s_q + 4'd1)) | pos;
    rev_idx   = ADDR_WIDTH'(bit_reverse(idx_q[FFT_MAX_LOG2N-1:0], m_q));
    rd_en     = 1'b0;
    rd_bypass = 1'b0;
    rd_a      = '0;
    rd_b      = '0;
    tw        = '0;
    case (state_q)
      ST_BITREV: begin
        if (rev_idx > idx_q) begin
          rd_en     = 1'b1;
          rd_bypass = 1'b1;
          rd_a      = idx_q;
          rd_b      = rev_idx;
        end
      end
      ST_BFLY: begin
        rd_en = 1'b1;
        rd_a  = bf_a;
        rd_b  = bf_a + span;
        tw    = (ADDR_WIDTH-1)'(pos << (m_q - 4'd1 - s_q));
      end
      default: ;
    endcase
  end

  assign dl_in = {rd_en, rd_bypass, rd_a, rd_b};

  fft_delay_line #(
    .WIDTH (DL_WIDTH),
    .DEPTH (BF_LATENCY)
  ) u_wb_delay (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_flush (i_abort),
    .i_data  (dl_in),
    .o_data  (dl_out)
  );

  assign o_wr_en     = dl_out[DL_WIDTH-1];
  assign wr_bypass   = dl_out[DL_WIDTH-2];
  assign wr_a        = dl_out[2*ADDR_WIDTH-1:ADDR_WIDTH];
  assign wr_b        = dl_out[ADDR_WIDTH-1:0];
  assign o_wr_addr_a = wr_bypass ? wr_b : wr_a;
  assign o_wr_addr_b = wr_bypass ? wr_a : wr_b;

  assign o_busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_calc_end  = (state_q == ST_DONE);
  assign o_cfg_err   = cfg_err_q;
  assign o_stage     = s_q;
  assign o_rd_en     = rd_en;
  assign o_rd_addr_a = rd_a;
  assign o_rd_addr_b = rd_b;
  assign o_tw_idx    = tw;
  assign o_bf_bypass = rd_bypass;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: a reference model queues every
// expected read pair and write-back, a monitor pops them as the DUT emits them.
module tb_fft_stage_sequencer;

  localparam int AW  = 12;
  localparam int LAT = 4;

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic          i_start;
  logic          i_abort;
  logic [AW-1:0] i_samples_number;
  logic          o_busy, o_calc_end, o_cfg_err;
  logic [3:0]    o_stage;
  logic          o_rd_en, o_bf_bypass, o_wr_en;
  logic [AW-1:0] o_rd_addr_a, o_rd_addr_b, o_wr_addr_a, o_wr_addr_b;
  logic [AW-2:0] o_tw_idx;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int rd_pops  = 0;
  int target   = 0;

  // {cycle[15:0], stage[3:0], bypass, addr_a[11:0], addr_b[11:0], tw[10:0]}
  logic [55:0] rd_q[$];
  // {cycle[15:0], wr_addr_a[11:0], wr_addr_b[11:0]}
  logic [39:0] wr_q[$];

  fft_stage_sequencer #(
    .ADDR_WIDTH (AW),
    .BF_LATENCY (LAT)
  ) dut (
    .i_clk            (i_clk),
    .i_rstn           (i_rstn),
    .i_start          (i_start),
    .i_abort          (i_abort),
    .i_samples_number (i_samples_number),
    .o_busy           (o_busy),
    .o_calc_end       (o_calc_end),
    .o_cfg_err        (o_cfg_err),
    .o_stage          (o_stage),
    .o_rd_en          (o_rd_en),
    .o_rd_addr_a      (o_rd_addr_a),
    .o_rd_addr_b      (o_rd_addr_b),
    .o_tw_idx         (o_tw_idx),
    .o_bf_bypass      (o_bf_bypass),
    .o_wr_en          (o_wr_en),
    .o_wr_addr_a      (o_wr_addr_a),
    .o_wr_addr_b      (o_wr_addr_b)
  );

  initial forever #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"},
                64'({o_busy, o_calc_end, o_cfg_err, o_stage, o_rd_en, o_bf_bypass, o_wr_en}),
                64'd0);
    checkOutput({tag, "_rd"}, 64'({o_rd_addr_a, o_rd_addr_b, o_tw_idx}), 64'd0);
    checkOutput({tag, "_wr"}, 64'({o_wr_addr_a, o_wr_addr_b}), 64'd0);
  endtask

  // Reference model: expected issue order and cycle of every pair for frame n
  // started in cycle t0 - 1.
  task automatic buildModel(input int n, input int t0);
    int m, r, a, b, pos, tw, c, base;
    m = 0;
    while ((1 << m) < n) m++;
    for (int i = 0; i < n; i++) begin
      r = 0;
      for (int j = 0; j < m; j++) begin
        if (((i >> j) & 1) != 0) r = r | (1 << (m - 1 - j));
      end
      if (r > i) begin
        c = t0 + i;
        rd_q.push_back({16'(c), 4'd0, 1'b1, 12'(i), 12'(r), 11'd0});
        wr_q.push_back({16'(c + LAT), 12'(r), 12'(i)});
      end
    end
    base = t0 + n + LAT;
    for (int s = 0; s < m; s++) begin
      for (int k = 0; k < n / 2; k++) begin
        pos = k % (1 << s);
        a   = (k / (1 << s)) * (2 << s) + pos;
        b   = a + (1 << s);
        tw  = pos * (n / (2 << s));
        c   = base + s * (n / 2 + LAT) + k;
        rd_q.push_back({16'(c), 4'(s), 1'b0, 12'(a), 12'(b), 11'(tw)});
        wr_q.push_back({16'(c + LAT), 12'(a), 12'(b)});
      end
    end
  endtask

  // One-cycle i_start pulse with frame size n; legal frames load the scoreboard.
  task automatic applyStimulus(input int n);
    @(posedge i_clk);
    #1;
    i_samples_number = AW'(n);
    i_start          = 1'b1;
    start_cyc        = cyc;
    rd_pops          = 0;
    if (n >= 2 && n <= 2048 && (n & (n - 1)) == 0) buildModel(n, cyc + 1);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic waitCalcEnd(input int expected_offset, input string tag);
    int found;
    found = -1;
    for (int c = 0; c < 300 && found < 0; c++) begin
      @(negedge i_clk);
      if (o_calc_end === 1'b1) found = cyc - start_cyc;
    end
    checkOutput(tag, 64'(found), 64'(expected_offset));
  endtask

  task automatic waitUntilCycle(input int t);
    while (cyc < t) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic monitorLoop();
    logic [55:0] exp_rd;
    logic [39:0] exp_wr;
    forever begin
      @(negedge i_clk);
      if (o_rd_en !== 1'b0) begin
        if (rd_q.size() == 0) begin
          checkOutput("rd_unexpected", 64'(o_rd_en), 64'd0);
        end else begin
          exp_rd = rd_q.pop_front();
          rd_pops++;
          checkOutput("rd_pair",
                      64'({16'(cyc), o_stage, o_bf_bypass, o_rd_addr_a, o_rd_addr_b, o_tw_idx}),
                      64'(exp_rd));
        end
      end
      if (o_wr_en !== 1'b0) begin
        if (wr_q.size() == 0) begin
          checkOutput("wr_unexpected", 64'(o_wr_en), 64'd0);
        end else begin
          exp_wr = wr_q.pop_front();
          checkOutput("wr_pair", 64'({16'(cyc), o_wr_addr_a, o_wr_addr_b}), 64'(exp_wr));
        end
      end
    end
  endtask

  initial begin
    int bad_n[3];
    bad_n[0] = 6;
    bad_n[1] = 0;
    bad_n[2] = 4095;
    i_rstn = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_samples_number = '0;
    fork
      monitorLoop();
    join_none

    repeat (2) @(negedge i_clk);
    checkAllZero("reset");
    i_rstn = 1'b1;
    @(negedge i_clk);
    checkAllZero("idle");

    $display("[TB] N=8 frame");
    applyStimulus(8);
    @(negedge i_clk);
    checkOutput("busy_bitrev", 64'(o_busy), 64'd1);
    waitCalcEnd(37, "calc_end_n8");
    checkOutput("pairs_n8", 64'(rd_pops), 64'd14);
    checkOutput("rdq_left_n8", 64'(rd_q.size()), 64'd0);
    checkOutput("wrq_left_n8", 64'(wr_q.size()), 64'd0);
    checkOutput("busy_done", 64'(o_busy), 64'd0);
    @(negedge i_clk);
    checkOutput("calc_end_hold", 64'(o_calc_end), 64'd1);

    @(posedge i_clk);
    #1;
    i_abort = 1'b1;
    @(posedge i_clk);
    #1;
    i_abort = 1'b0;
    @(negedge i_clk);
    checkOutput("calc_end_after_abort", 64'(o_calc_end), 64'd0);

    $display("[TB] illegal frame sizes");
    foreach (bad_n[j]) begin
      applyStimulus(bad_n[j]);
      @(negedge i_clk);
      checkOutput("cfg_err_pulse", 64'(o_cfg_err), 64'd1);
      checkOutput("cfg_err_busy", 64'(o_busy), 64'd0);
      @(negedge i_clk);
      checkOutput("cfg_err_clear", 64'(o_cfg_err), 64'd0);
      checkOutput("cfg_err_busy2", 64'(o_busy), 64'd0);
    end

    $display("[TB] N=2 frame");
    applyStimulus(2);
    waitCalcEnd(12, "calc_end_n2");
    checkOutput("pairs_n2", 64'(rd_pops), 64'd1);

    $display("[TB] abort during stage 1 of N=16");
    applyStimulus(16);
    target = start_cyc + 35;
    waitUntilCycle(target);
    i_abort = 1'b1;
    @(posedge i_clk);
    #1;
    i_abort = 1'b0;
    rd_q.delete();
    wr_q.delete();
    checkOutput("pairs_before_abort", 64'(rd_pops), 64'd17);
    @(negedge i_clk);
    checkOutput("abort_busy", 64'(o_busy), 64'd0);
    checkOutput("abort_wr_en", 64'(o_wr_en), 64'd0);
    checkOutput("abort_rd_en", 64'(o_rd_en), 64'd0);
    repeat (5) begin
      @(negedge i_clk);
      checkOutput("abort_wr_quiet", 64'(o_wr_en), 64'd0);
    end

    applyStimulus(16);
    waitCalcEnd(69, "calc_end_n16");
    checkOutput("pairs_n16", 64'(rd_pops), 64'd38);
    checkOutput("wrq_left_n16", 64'(wr_q.size()), 64'd0);

    $display("[TB] async reset mid-BFLY");
    applyStimulus(8);
    target = start_cyc + 15;
    waitUntilCycle(target);
    #2;
    i_rstn = 1'b0;
    rd_q.delete();
    wr_q.delete();
    #1;
    checkAllZero("async_reset");
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    applyStimulus(8);
    waitCalcEnd(37, "calc_end_after_reset");
    checkOutput("pairs_after_reset", 64'(rd_pops), 64'd14);

    repeat (2) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
